// File: rtl/byteen_reg_bank.sv
// Byte-enabled register bank: DEPTH words of 8*NBYTES bits with per-byte written flags,
// one write port, one registered read port with write-first bypass and a synchronous bulk clear.
module byteen_reg_bank #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned DW    = 8 * NBYTES,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NBYTES-1:0] wr_be,
  input  logic [DW-1:0]     wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic [NBYTES-1:0] rd_written,
  output logic              wr_err
);

  logic [DW-1:0]     r_mem     [DEPTH];
  logic [NBYTES-1:0] r_written [DEPTH];

  logic              r_rd_valid;
  logic [DW-1:0]     r_rd_data;
  logic [NBYTES-1:0] r_rd_written;
  logic              r_wr_err;

  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_wr_go;
  logic              w_bypass;
  logic [DW-1:0]     w_be_mask;
  logic [DW-1:0]     w_rd_word;
  logic [NBYTES-1:0] w_rd_flags;
  logic [DW-1:0]     w_rd_data_d;
  logic [NBYTES-1:0] w_rd_written_d;

  assign w_wr_in_range = 32'(wr_addr) < DEPTH;
  assign w_rd_in_range = 32'(rd_addr) < DEPTH;
  assign w_wr_go       = wr_en && w_wr_in_range && !clr;
  assign w_bypass      = w_wr_go && (wr_addr == rd_addr);

  always_comb begin
    w_be_mask = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      w_be_mask[8*i +: 8] = {8{wr_be[i]}};
    end
  end

  // Out-of-range reads must not index the arrays; they return all zeros.
  always_comb begin
    w_rd_word  = '0;
    w_rd_flags = '0;
    if (w_rd_in_range) begin
      w_rd_word  = r_mem[rd_addr];
      w_rd_flags = r_written[rd_addr];
    end
  end

  always_comb begin
    w_rd_data_d    = w_rd_word;
    w_rd_written_d = w_rd_flags;
    if (clr) begin
      w_rd_data_d    = '0;
      w_rd_written_d = '0;
    end else if (w_bypass) begin
      w_rd_data_d    = (wr_data & w_be_mask) | (w_rd_word & ~w_be_mask);
      w_rd_written_d = w_rd_flags | wr_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      for (int w = 0; w < int'(DEPTH); w++) begin
        r_mem[w]     <= '0;
        r_written[w] <= '0;
      end
    end else if (w_wr_go) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
          r_written[wr_addr][i]    <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_written <= '0;
      r_wr_err     <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      r_wr_err   <= wr_en && !w_wr_in_range && !clr;
      if (rd_en) begin
        r_rd_data    <= w_rd_data_d;
        r_rd_written <= w_rd_written_d;
      end
    end
  end

  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign rd_written = r_rd_written;
  assign wr_err     = r_wr_err;

endmodule

// File: doc/byteen_reg_bank.md
Name: byteen_reg_bank

Overview:
- Parametrised, byte-enabled register bank: DEPTH words of 8*NBYTES bits each.
- Each byte lane has its own write enable and a per-byte "written" flag.
- One write port and one registered read port, with write-first bypass and a synchronous bulk clear.
- Used as a small configuration/scratch store wherever a single byte-enabled flop register is no longer enough.

Parameters:
- NBYTES, 4, number of byte lanes per word; data width DW = 8*NBYTES.
- DEPTH, 8, number of words; address width AW = max(1, clog2(DEPTH)) is derived, not a parameter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- resetn  input  1  reset, synchronous, active-low.
- clr  input  1  synchronous bulk clear of all words and written flags.
- wr_en  input  1  write request.
- wr_addr  input  AW  write word address.
- wr_be  input  NBYTES  per-byte write enable; bit i covers data bits [8i+7:8i].
- wr_data  input  DW  write data.
- rd_en  input  1  read request.
- rd_addr  input  AW  read word address.
- rd_valid  output  1  rd_data and rd_written hold a response to a read issued last cycle.
- rd_data  output  DW  read data, registered.
- rd_written  output  NBYTES  per-byte written-since-clear flags of the word read, registered.
- wr_err  output  1  registered; pulses 1 cycle after a write to an address >= DEPTH.

Behaviour:
- Reset (resetn=0 at posedge):
  - every word = 0; every written flag = 0.
  - rd_valid = 0, rd_data = 0, rd_written = 0, wr_err = 0.
  - Reset overrides clr, wr_en and rd_en in the same cycle, including mid-stream traffic.
- Write (wr_en=1, wr_addr < DEPTH):
  - At the posedge, only lanes with wr_be[i]=1 update: word[wr_addr] byte i <= wr_data byte i, and written[wr_addr][i] <= 1.
  - Lanes with wr_be[i]=0 keep their value and flag.
  - wr_be = 0 is a legal no-op: no change, no error.
- Out-of-range write (wr_addr >= DEPTH, only possible when DEPTH is not a power of 2):
  - storage unchanged; wr_err = 1 for exactly the next cycle, otherwise 0.
- Read latency is 1 cycle:
  - rd_en=1 at edge N gives rd_valid=1 after edge N, with rd_data/rd_written for rd_addr.
  - rd_en=0 gives rd_valid=0; rd_data and rd_written hold their last values.
- Out-of-range read: rd_valid=1, rd_data=0, rd_written=0.
- Write-first bypass: a read and write to the same in-range address in the same cycle returns the merged word.
  - Enabled lanes come from wr_data; the others come from stored data.
  - rd_written = stored flags OR wr_be.
- clr=1 (with resetn=1):
  - all words and flags become 0 at the edge.
  - clr takes priority over a same-cycle write; the write is dropped and wr_err stays 0.
  - A same-cycle read returns rd_valid=1, rd_data=0, rd_written=0 (clear-first).
  - clr does not touch rd_valid/rd_data of the previous response until the next edge.
- Simultaneous writes to different lanes of the same word across consecutive cycles accumulate. There is no hazard; each edge merges into the current stored value.
- Back-to-back reads every cycle: one response per cycle, in order, no bubbles.

Test Plan:
- Reset then read addr 0..7 back-to-back -> 8 consecutive cycles of rd_valid=1, rd_data=0x00000000, rd_written=0x0; rd_valid=0 the cycle after rd_en drops.
- Write addr 3, be=0x5, data=0xAABBCCDD; next cycle write addr 3, be=0x2, data=0x11223344; then read addr 3 -> rd_data=0x00BB33DD, rd_written=0x7.
- Same-cycle write addr 5, be=0xC, data=0xDEADBEEF with read addr 5 (word previously 0x01020304, written=0x3) -> rd_data=0xDEAD0304, rd_written=0xF next cycle.
- clr asserted together with a write to addr 2 and a read of addr 2 (word was 0x12345678, written=0xF) -> rd_data=0, rd_written=0; a later read of addr 2 still returns 0 with written=0x0.
- DEPTH=6: write addr 7, be=0xF -> wr_err=1 for one cycle and all words unchanged; read addr 7 -> rd_valid=1, rd_data=0.
- resetn low for one cycle between a write issue and its readback (addr 1 written 0xCAFEF00D) -> readback returns 0, written=0x0, rd_valid=0 in the cycle after reset.
